// File: rtl/convolutor_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : convolutor_pkg
//  Purpose  : Shared types and sizing helpers for the convolution address
//             sequencer and its comparators.
//  Contents : seq_state_t       - sequencer state encoding
//             DEFAULT_ADDR_WIDTH - default X/Y memory address width
//             IDX_GUARD_BITS     - extra index bits so that i-NY+1 and
//                                  NX+NY-2 never overflow
//             idx_width()        - internal i/k width for an address width
//             max_size()         - largest legal operand length
//  Revision : 1.0 - initial release
// ============================================================================
package convolutor_pkg;

   localparam int DEFAULT_ADDR_WIDTH = 5;
   localparam int IDX_GUARD_BITS     = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } seq_state_t;

   function automatic int idx_width(input int addr_width);
      return addr_width + IDX_GUARD_BITS;
   endfunction

   function automatic int max_size(input int addr_width);
      return 1 << addr_width;
   endfunction

endpackage : convolutor_pkg
`default_nettype wire

// File: rtl/convolutor_std_comparator_p.sv
`default_nettype none
// ============================================================================
//  Module   : convolutor_std_comparator_p
//  Purpose  : Parameterised unsigned comparator, purely combinational.
//  Params   : WIDTH - operand width
//             TYPE  - 0: a == b   1: a != b   2: a < b
//                     3: a <= b   4: a > b    5: a >= b
//  Ports    : a  in  WIDTH  left operand
//             b  in  WIDTH  right operand
//             y  out 1      comparison result
//  Revision : 1.0 - initial release
// ============================================================================
module convolutor_std_comparator_p #(
   parameter int WIDTH = 8,
   parameter int TYPE  = 0
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             y
);

   generate
      if (TYPE == 0) begin : g_eq
         assign y = (a == b);
      end else if (TYPE == 1) begin : g_ne
         assign y = (a != b);
      end else if (TYPE == 2) begin : g_lt
         assign y = (a < b);
      end else if (TYPE == 3) begin : g_le
         assign y = (a <= b);
      end else if (TYPE == 4) begin : g_gt
         assign y = (a > b);
      end else begin : g_ge
         assign y = (a >= b);
      end
   endgenerate

endmodule : convolutor_std_comparator_p
`default_nettype wire

// File: rtl/convolutor_addr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : convolutor_addr_sequencer
//  Purpose  : Walks the full linear convolution Z = X * Y and emits one
//             (X addr, Y addr, Z addr) term per accepted handshake, with
//             first/last markers for the downstream accumulator.
//  Ports    : clk_i        in   1             clock, rising edge
//             rst_i        in   1             synchronous reset, active high
//             start_i      in   1             begin a run (sampled in IDLE)
//             size_x_i     in   ADDR_WIDTH+1  NX
//             size_y_i     in   ADDR_WIDTH+1  NY
//             busy_o       out  1             not IDLE
//             done_o       out  1             one-cycle end-of-run pulse
//             error_o      out  1             sticky size error
//             term_valid_o out  1             term available
//             term_ready_i in   1             downstream accepts the term
//             addr_x_o     out  ADDR_WIDTH    k
//             addr_y_o     out  ADDR_WIDTH    i-k
//             addr_z_o     out  ADDR_WIDTH+1  i
//             first_o      out  1             first term of Z[i]
//             last_o       out  1             last term of Z[i]
//  Revision : 1.0 - initial release
// ============================================================================
module convolutor_addr_sequencer
   import convolutor_pkg::*;
#(
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH:0]   size_x_i,
   input  logic [ADDR_WIDTH:0]   size_y_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  error_o,
   output logic                  term_valid_o,
   input  logic                  term_ready_i,
   output logic [ADDR_WIDTH-1:0] addr_x_o,
   output logic [ADDR_WIDTH-1:0] addr_y_o,
   output logic [ADDR_WIDTH:0]   addr_z_o,
   output logic                  first_o,
   output logic                  last_o
);

   localparam int                IDX_W    = idx_width(ADDR_WIDTH);
   localparam logic [ADDR_WIDTH:0] MAX_SIZE = (ADDR_WIDTH+1)'(max_size(ADDR_WIDTH));

   seq_state_t       state;
   logic [ADDR_WIDTH:0] nx;
   logic [ADDR_WIDTH:0] ny;
   logic [IDX_W-1:0] i;
   logic [IDX_W-1:0] k;
   logic [IDX_W-1:0] k_end;

   logic [IDX_W-1:0] nx_ext;
   logic [IDX_W-1:0] ny_ext;
   logic [IDX_W-1:0] last_i;
   logic [IDX_W-1:0] k_start_calc;
   logic [IDX_W-1:0] k_end_calc;
   logic [IDX_W-1:0] k_next;
   logic [IDX_W-1:0] k_end_next;
   logic             i_lt_nx;
   logic             i_lt_ny;
   logic             i_is_last;
   logic             next_is_last;
   logic             sizes_bad;

   assign nx_ext = IDX_W'(nx);
   assign ny_ext = IDX_W'(ny);
   assign last_i = nx_ext + ny_ext - IDX_W'(2);

   assign sizes_bad = (size_x_i == '0) || (size_x_i > MAX_SIZE) ||
                      (size_y_i == '0) || (size_y_i > MAX_SIZE);

   // k_next / k_end_next describe the term that will be presented next:
   // in SETUP the first term of Z[i], in RUN the successor of the current
   // term. Comparing them up front lets last_o be a plain register, and the
   // RUN state uses that registered flag as its k == k_end decision.
   always_comb begin
      k_start_calc = i_lt_ny ? '0 : (i - ny_ext + IDX_W'(1));
      k_end_calc   = i_lt_nx ? i  : (nx_ext - IDX_W'(1));
      k_next       = k_start_calc;
      k_end_next   = k_end_calc;
      if (state == RUN) begin
         k_next     = k + IDX_W'(1);
         k_end_next = k_end;
      end
   end

   convolutor_std_comparator_p #(.WIDTH(IDX_W), .TYPE(0)) u_cmp_k_last (
      .a (k_next),
      .b (k_end_next),
      .y (next_is_last)
   );

   convolutor_std_comparator_p #(.WIDTH(IDX_W), .TYPE(0)) u_cmp_i_last (
      .a (i),
      .b (last_i),
      .y (i_is_last)
   );

   convolutor_std_comparator_p #(.WIDTH(IDX_W), .TYPE(2)) u_cmp_i_lt_nx (
      .a (i),
      .b (nx_ext),
      .y (i_lt_nx)
   );

   convolutor_std_comparator_p #(.WIDTH(IDX_W), .TYPE(2)) u_cmp_i_lt_ny (
      .a (i),
      .b (ny_ext),
      .y (i_lt_ny)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= IDLE;
         nx           <= '0;
         ny           <= '0;
         i            <= '0;
         k            <= '0;
         k_end        <= '0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         error_o      <= 1'b0;
         term_valid_o <= 1'b0;
         addr_x_o     <= '0;
         addr_y_o     <= '0;
         addr_z_o     <= '0;
         first_o      <= 1'b0;
         last_o       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_i) begin
                  nx      <= size_x_i;
                  ny      <= size_y_i;
                  i       <= '0;
                  k       <= '0;
                  k_end   <= '0;
                  busy_o  <= 1'b1;
                  error_o <= sizes_bad;
                  if (sizes_bad) begin
                     done_o <= 1'b1;
                     state  <= DONE;
                  end else begin
                     state  <= SETUP;
                  end
               end
            end

            SETUP: begin
               k            <= k_next;
               k_end        <= k_end_next;
               term_valid_o <= 1'b1;
               addr_x_o     <= ADDR_WIDTH'(k_next);
               addr_y_o     <= ADDR_WIDTH'(i - k_next);
               addr_z_o     <= (ADDR_WIDTH+1)'(i);
               first_o      <= 1'b1;
               last_o       <= next_is_last;
               state        <= RUN;
            end

            RUN: begin
               if (term_ready_i) begin
                  if (!last_o) begin
                     k        <= k_next;
                     addr_x_o <= ADDR_WIDTH'(k_next);
                     addr_y_o <= ADDR_WIDTH'(i - k_next);
                     first_o  <= 1'b0;
                     last_o   <= next_is_last;
                  end else begin
                     // Final term of Z[i] accepted: drop the term outputs
                     // and either finish or move on to the next sample.
                     term_valid_o <= 1'b0;
                     addr_x_o     <= '0;
                     addr_y_o     <= '0;
                     addr_z_o     <= '0;
                     first_o      <= 1'b0;
                     last_o       <= 1'b0;
                     if (i_is_last) begin
                        done_o <= 1'b1;
                        state  <= DONE;
                     end else begin
                        i      <= i + IDX_W'(1);
                        state  <= SETUP;
                     end
                  end
               end
            end

            DONE: begin
               done_o <= 1'b0;
               busy_o <= 1'b0;
               state  <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule : convolutor_addr_sequencer
`default_nettype wire
